// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the instruction memory and
// hands captured words to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] read_addr,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [31:0] word_idx;
  logic        in_range;
  logic        consume;
  logic        advance;

  assign word_idx  = {2'b00, pc_q[31:2]};
  assign read_addr = word_idx;
  assign in_range  = (word_idx < IMEM_DEPTH);
  assign consume   = if_valid_q && if_ready;
  assign advance   = (state_q == ST_RUN) && !redirect_valid && in_range &&
                     (!if_valid_q || if_ready);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (redirect_valid) begin
          // A redirect always flushes, even a word decode is accepting now.
          if_valid_d = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
            if (state_q == ST_IDLE && fetch_en) begin
              state_d = ST_RUN;
            end
          end else begin
            state_d       = ST_FAULT;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_MISALIGN;
            fault_pc_d    = redirect_pc;
          end
        end else begin
          if (advance) begin
            if_instr_d = instr_in;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else if (consume) begin
            if_valid_d = 1'b0;
          end

          if (state_q == ST_IDLE) begin
            if (fetch_en) begin
              state_d = ST_RUN;
            end
          end else if (!in_range) begin
            state_d       = ST_FAULT;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_RANGE;
            fault_pc_d    = pc_q;
          end else if (!fetch_en) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      fault_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester side of the instruction memory interface.
- Owns the program counter, drives the word address into the instruction memory, and captures the returned word.
- Presents the captured word to decode over a valid/ready handshake.
- Also handles stall (backpressure), redirect (branch/jump), start/stop, and sticky fault detection.
- Sits between instruction_memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 64, number of 32-bit words in the instruction memory; word indices >= IMEM_DEPTH are out of range.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  level; 1 = fetch, 0 = pause after the current output is consumed.
- read_addr  output  32  word index to the instruction memory, {2'b00, pc[31:2]}.
- instr_in  input  32  word returned by the memory; combinational from read_addr, same cycle.
- redirect_valid  input  1  one-cycle pulse: load redirect_pc.
- redirect_pc  input  32  new byte-address PC.
- if_valid  output  1  if_instr/if_pc hold a valid instruction.
- if_ready  input  1  decode accepts when if_valid && if_ready.
- if_instr  output  32  captured instruction.
- if_pc  output  32  byte address of if_instr.
- fault  output  1  sticky; fetch halted.
- fault_cause  output  2  2'b00 none, 2'b01 misaligned redirect, 2'b10 out-of-range PC.
- fault_pc  output  32  PC value that caused the fault.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - if_valid=0, if_instr=0, if_pc=0.
  - fault=0, fault_cause=0, fault_pc=0.
  - Reset mid-operation discards any held instruction immediately.
- States:
  - IDLE: no fetch. fetch_en=1 -> RUN.
  - RUN: fetching. fetch_en=0 -> IDLE. A range fault -> FAULT.
  - FAULT: terminal until reset. pc, if_* and fault_* are frozen; redirect_valid and fetch_en are ignored.
  - From IDLE or RUN, a misaligned redirect -> FAULT.
- read_addr is always {2'b00, pc[31:2]}, combinational from the pc register.
- advance = (state==RUN) && !redirect_valid && (pc[31:2] < IMEM_DEPTH) && (!if_valid || if_ready).
- On advance: if_instr<=instr_in, if_pc<=pc, if_valid<=1, pc<=pc+4.
  - Full throughput is one instruction per cycle while if_ready=1.
- If if_valid && if_ready && !advance: if_valid<=0.
- Stall: when if_valid && !if_ready, if_instr, if_pc, if_valid and pc are all held.
- Redirect (IDLE or RUN, redirect_valid=1) has priority over advance and fetch_en:
  - if_valid<=0; the held instruction is flushed even if if_ready=1 that cycle.
  - If redirect_pc[1:0]==0: pc<=redirect_pc; state is unchanged, except that IDLE still moves to RUN when fetch_en=1.
  - If redirect_pc[1:0]!=0: state<=FAULT, fault<=1, fault_cause<=2'b01, fault_pc<=redirect_pc; pc is unchanged.
- Range fault: in RUN with no redirect and pc[31:2] >= IMEM_DEPTH:
  - state<=FAULT, fault<=1, fault_cause<=2'b10, fault_pc<=pc.
  - No capture. An already-valid if_* is kept until consumed.
- Latency:
  - fetch_en rises in IDLE; edge 1 -> RUN; edge 2 -> if_valid=1 with if_pc=pc.
  - After a redirect edge, the first redirected instruction appears after the next edge.
- Pause: when fetch_en drops in RUN, the state becomes IDLE at the next edge, and the advance evaluated in that same cycle still occurs. A held if_valid stays until consumed.
- pc+4 uses modulo-2^32 arithmetic; the range check normally faults before any wrap.
- Only RUN captures; IDLE never captures even if if_valid=0.

Test Plan:
- Reset, fetch_en=1, if_ready=1, mem[k]=32'h1000_0000+k -> if_valid rises on the 2nd edge; if_pc/if_instr = 0/10000000, 4/10000001, 8/10000002 on consecutive cycles; read_addr = 0,1,2,3.
- Steady fetch, drop if_ready for 3 cycles while if_pc=8 -> if_instr=10000002 and read_addr=3 held; on release, the next cycle shows if_pc=12.
- redirect_valid with redirect_pc=32'h40 while if_valid=1, if_ready=1 -> next cycle if_valid=0, read_addr=16; the following cycle if_pc=32'h40, if_instr=mem[16].
- redirect_pc=32'h42 -> fault=1, fault_cause=01, fault_pc=32'h42, if_valid=0; fetch_en and further redirects are ignored until rst_n pulse, after which pc=0.
- Run sequentially to pc=32'h100 (word 64) with IMEM_DEPTH=64 -> last valid if_pc=32'hFC; then fault=1, fault_cause=10, fault_pc=32'h100; the FC instruction is still delivered.
- Assert rst_n=0 mid-stall with if_valid=1 -> if_valid=0 and pc=RESET_PC immediately, without a clock edge.
